// File: rtl/des_pkg.sv
// Shared DES round constants: P wiring, S-box contents and the round-engine FSM encoding.
// All tables are written in DES order, so the first entry corresponds to DES bit 1 or S-box index 0.
package des_pkg;

    localparam int NUM_ROUNDS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box holds 64 entries, row-major (index = row*16 + col), with entry 0 in the top nibble.
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] idx);
        logic [255:0] t;
        t = SBOX_TBL[box] >> (9'd252 - {1'b0, idx, 2'b00});
        return t[3:0];
    endfunction

endpackage

// File: rtl/des_sbox.sv
// One DES S-box: 6-bit group in, 4-bit result out, both buses with index 0 = DES bit 1.
// Row is formed from DES bits 1 and 6, column from DES bits 2..5.
module des_sbox
    import des_pkg::*;
#(
    parameter int BOX = 0
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);

    logic [5:0] idx;
    logic [3:0] val;

    assign idx  = {din[0], din[5], din[1], din[2], din[3], din[4]};
    assign val  = sbox_lookup(3'(BOX), idx);
    assign dout = {val[0], val[1], val[2], val[3]};

endmodule

// File: rtl/e_function.sv
// DES expansion E: 32 -> 48 bits, bus index n carries DES bit n+1.
// Output group g (six bits) takes input bits 4g-1 .. 4g+4 modulo 32.
module e_function (
    input  logic [31:0] r,
    output logic [47:0] e
);

    for (genvar g = 0; g < 8; g++) begin : g_grp
        for (genvar k = 0; k < 6; k++) begin : g_bit
            assign e[6*g + k] = r[(4*g + k + 31) % 32];
        end
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock on a post-IP L/R pair, subkeys fetched by index.
// Result is the pre-FP block (R16, L16) held on left_out/right_out until the next accepted start.
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] left_in,
    input  logic [31:0] right_in,
    input  logic        decrypt,
    output logic [3:0]  key_idx,
    input  logic [47:0] subkey,
    output logic        busy,
    output logic        done,
    output logic [31:0] left_out,
    output logic [31:0] right_out
);

    state_t      state, state_nxt;
    logic [3:0]  round;
    logic [31:0] l_reg, r_reg;
    logic        dec;
    logic        accept, last_round;
    logic [47:0] e_out, xored;
    logic [31:0] s_out, p_out, r_new;

    assign accept     = start && (state != RUN);
    assign last_round = (state == RUN) && (round == 4'(NUM_ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_round) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outside RUN the index parks at 0 regardless of direction.
    assign key_idx = (state != RUN) ? 4'd0 : (dec ? 4'd15 - round : round);

    e_function u_e (
        .r (r_reg),
        .e (e_out)
    );

    assign xored = e_out ^ subkey;

    for (genvar i = 0; i < 8; i++) begin : g_sbox
        des_sbox #(.BOX(i)) u_sbox (
            .din  (xored[6*i +: 6]),
            .dout (s_out[4*i +: 4])
        );
    end

    for (genvar j = 0; j < 32; j++) begin : g_p
        assign p_out[j] = s_out[P_TBL[j] - 1];
    end

    assign r_new = l_reg ^ p_out;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            round     <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            dec       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                l_reg <= left_in;
                r_reg <= right_in;
                round <= '0;
                dec   <= decrypt;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                l_reg <= r_reg;
                r_reg <= r_new;
                round <= last_round ? 4'd0 : round + 4'd1;
                if (last_round) begin
                    left_out  <= r_new;
                    right_out <= r_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule
